// File: rtl/tdm_slot_decoder.sv
// Receive side of the round-robin TDM slot stream: undoes the chained-XOR bit
// encoding, tracks the slot index and steers each word into its channel register.
module tdm_slot_decoder #(
   parameter int WD  = 4,
   parameter int NCH = 5
) (
   input  logic                    CLK,
   input  logic                    RSTX,
   input  logic [WD-1:0]           DIN,
   input  logic                    DVALID,
   input  logic                    DSYNC,
   input  logic                    ERR_CLR,
   output logic [NCH-1:0][WD-1:0]  OUT,
   output logic [NCH-1:0]          OVALID,
   output logic                    FRAME_DONE,
   output logic [2:0]              SLOT,
   output logic                    SYNC_ERR
);

   localparam logic [2:0] LAST = 3'(NCH - 1);

   typedef struct packed {
      logic          vld;
      logic [2:0]    slot;
      logic [WD-1:0] data;
   } wr_req_t;

   logic [WD-1:0] dec;
   wr_req_t       req;
   logic          misalign;

   // Serial ripple: each decoded bit depends on the previously decoded one.
   always_comb begin
      dec    = '0;
      dec[0] = DIN[0];
      for (int j = 1; j < WD; j++)
         dec[j] = DIN[j] ^ ~dec[j-1];
   end

   always_comb begin
      req      = '0;
      req.vld  = DVALID;
      req.slot = DSYNC ? 3'd0 : SLOT;
      req.data = dec;
      misalign = DVALID && DSYNC && (SLOT != 3'd0);
   end

   always_ff @(posedge CLK) begin
      if (!RSTX) begin
         SLOT       <= 3'd0;
         FRAME_DONE <= 1'b0;
         SYNC_ERR   <= 1'b0;
      end else begin
         FRAME_DONE <= req.vld && (req.slot == LAST);
         if (req.vld)
            SLOT <= (req.slot == LAST) ? 3'd0 : req.slot + 3'd1;
         // A fresh misalignment outranks a simultaneous clear.
         if (misalign)
            SYNC_ERR <= 1'b1;
         else if (ERR_CLR)
            SYNC_ERR <= 1'b0;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      logic wr;
      assign wr = req.vld && (req.slot == 3'(g));

      always_ff @(posedge CLK) begin
         if (!RSTX) begin
            OUT[g]    <= '0;
            OVALID[g] <= 1'b0;
         end else begin
            OVALID[g] <= wr;
            if (wr)
               OUT[g] <= req.data;
         end
      end
   end

endmodule

// File: tb/tb_tdm_slot_decoder.sv
// Directed bench for tdm_slot_decoder (WD=4, NCH=5) with hand-computed expectations.
module tb_tdm_slot_decoder;

   localparam int WD  = 4;
   localparam int NCH = 5;

   logic                   CLK = 1'b0;
   logic                   RSTX;
   logic [WD-1:0]          DIN;
   logic                   DVALID;
   logic                   DSYNC;
   logic                   ERR_CLR;
   logic [NCH-1:0][WD-1:0] OUT;
   logic [NCH-1:0]         OVALID;
   logic                   FRAME_DONE;
   logic [2:0]             SLOT;
   logic                   SYNC_ERR;

   int n_tests = 0;
   int n_fail  = 0;

   tdm_slot_decoder #(.WD(WD), .NCH(NCH)) dut (
      .CLK(CLK), .RSTX(RSTX), .DIN(DIN), .DVALID(DVALID), .DSYNC(DSYNC),
      .ERR_CLR(ERR_CLR), .OUT(OUT), .OVALID(OVALID), .FRAME_DONE(FRAME_DONE),
      .SLOT(SLOT), .SYNC_ERR(SYNC_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " out"}, 32'(OUT), 32'd0);
      chk({tag, " ovalid"}, 32'(OVALID), 32'd0);
      chk({tag, " frame_done"}, 32'(FRAME_DONE), 32'd0);
      chk({tag, " slot"}, 32'(SLOT), 32'd0);
      chk({tag, " sync_err"}, 32'(SYNC_ERR), 32'd0);
   endtask

   // Present one valid word for a single cycle, then go idle.
   task automatic send(input logic [WD-1:0] d, input logic s);
      DIN = d; DSYNC = s; DVALID = 1'b1;
      tick();
      DVALID = 1'b0; DSYNC = 1'b0;
   endtask

   logic [WD-1:0] words [NCH] = '{4'h0, 4'hF, 4'hE, 4'h0, 4'hF};
   logic [WD-1:0] decs  [NCH] = '{4'hA, 4'hF, 4'h0, 4'hA, 4'hF};
   int            fd_cnt;

   initial begin
      // 1: reset with live input activity
      RSTX = 1'b0; DVALID = 1'b1; DIN = 4'hF; DSYNC = 1'b0; ERR_CLR = 1'b0;
      tick();
      chk_all_zero("rst c1");
      tick();
      chk_all_zero("rst c2");
      RSTX = 1'b1; DVALID = 1'b0;
      tick();
      chk_all_zero("rst release");

      // 2: decode and fill one frame back to back
      for (int i = 0; i < NCH; i++) begin
         DIN = words[i]; DVALID = 1'b1; DSYNC = (i == 0);
         tick();
         chk($sformatf("fill out%0d", i), 32'(OUT[i]), 32'(decs[i]));
         chk($sformatf("fill ovalid%0d", i), 32'(OVALID), 32'(1 << i));
         chk($sformatf("fill fd%0d", i), 32'(FRAME_DONE), 32'(i == NCH-1));
         chk($sformatf("fill slot%0d", i), 32'(SLOT), 32'((i + 1) % NCH));
      end
      DVALID = 1'b0; DSYNC = 1'b0;
      tick();
      chk("fill idle ovalid", 32'(OVALID), 32'd0);
      chk("fill idle fd", 32'(FRAME_DONE), 32'd0);
      chk("fill out vec", 32'(OUT), 32'hFA0FA);

      // 3: same frame with idle gaps, from a clean reset
      RSTX = 1'b0; tick(); RSTX = 1'b1;
      chk("gap rst out", 32'(OUT), 32'd0);
      fd_cnt = 0;
      for (int i = 0; i < NCH; i++) begin
         DIN = words[i]; DVALID = 1'b1; DSYNC = (i == 0);
         tick();
         DVALID = 1'b0; DSYNC = 1'b0;
         if (FRAME_DONE) fd_cnt++;
         chk($sformatf("gap ovalid%0d", i), 32'(OVALID), 32'(1 << i));
         chk($sformatf("gap out%0d", i), 32'(OUT[i]), 32'(decs[i]));
         for (int k = 0; k < 3; k++) begin
            tick();
            if (FRAME_DONE) fd_cnt++;
            chk($sformatf("gap idle slot%0d.%0d", i, k), 32'(SLOT), 32'((i + 1) % NCH));
            chk($sformatf("gap idle ovalid%0d.%0d", i, k), 32'(OVALID), 32'd0);
         end
      end
      chk("gap frame_done count", 32'(fd_cnt), 32'd1);
      chk("gap out vec", 32'(OUT), 32'hFA0FA);

      // 4: misaligned DSYNC at SLOT=2, then clear
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      chk("mis pre slot", 32'(SLOT), 32'd2);
      chk("mis pre err", 32'(SYNC_ERR), 32'd0);
      DIN = 4'hF; DVALID = 1'b1; DSYNC = 1'b1;
      tick();
      DVALID = 1'b0; DSYNC = 1'b0;
      chk("mis out0", 32'(OUT[0]), 32'hF);
      chk("mis ovalid", 32'(OVALID), 32'b00001);
      chk("mis err", 32'(SYNC_ERR), 32'd1);
      chk("mis slot", 32'(SLOT), 32'd1);
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
      chk("clr err", 32'(SYNC_ERR), 32'd0);

      // DSYNC without DVALID must be ignored
      DSYNC = 1'b1;
      tick();
      DSYNC = 1'b0;
      chk("nv dsync err", 32'(SYNC_ERR), 32'd0);
      chk("nv dsync slot", 32'(SLOT), 32'd1);

      // 5: set/clear collision at SLOT=1 -- set wins
      DIN = 4'h0; DVALID = 1'b1; DSYNC = 1'b1; ERR_CLR = 1'b1;
      tick();
      DVALID = 1'b0; DSYNC = 1'b0; ERR_CLR = 1'b0;
      chk("coll err", 32'(SYNC_ERR), 32'd1);
      chk("coll out0", 32'(OUT[0]), 32'hA);
      chk("coll slot", 32'(SLOT), 32'd1);
      for (int i = 1; i < NCH; i++) send(4'hE, 1'b0);
      chk("coll wrap slot", 32'(SLOT), 32'd0);
      send(4'hF, 1'b1);
      chk("legal dsync err held 1", 32'(SYNC_ERR), 32'd1);
      chk("legal dsync slot", 32'(SLOT), 32'd1);
      ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
      chk("coll clr err", 32'(SYNC_ERR), 32'd0);
      for (int i = 1; i < NCH; i++) send(4'hE, 1'b0);
      send(4'h0, 1'b1);
      chk("legal dsync err held 0", 32'(SYNC_ERR), 32'd0);

      // 6: mid-frame reset with SYNC_ERR set, then one word without DSYNC
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      send(4'h3, 1'b1);
      chk("mid pre err", 32'(SYNC_ERR), 32'd1);
      chk("mid pre slot", 32'(SLOT), 32'd1);
      RSTX = 1'b0;
      tick();
      RSTX = 1'b1;
      chk_all_zero("mid rst");
      send(4'h0, 1'b0);
      chk("mid out0", 32'(OUT[0]), 32'hA);
      chk("mid ovalid", 32'(OVALID), 32'b00001);
      chk("mid slot", 32'(SLOT), 32'd1);
      chk("mid out vec", 32'(OUT), 32'h0000A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
